// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Purpose : shared definitions for the load/store front end: access-size
//           encodings, the controller state enum and the byte-lane mask
//           helper used by both the top level and the lane aligner.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Lane mask of an access. A halfword picks the upper or lower pair from
  // address bit 1. The reserved size yields an empty mask; such requests are
  // rejected before they reach the RAM anyway.
  function automatic logic [3:0] laneMask(input logic [1:0] size,
                                          input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SZ_B:    mask = 4'b0001 << offset;
      SZ_H:    mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : bundles the CPU-side request/response handshake and the RAM-side
//           bus of the load/store front end.
// Signals : req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/
//           req_wdata (request), resp_valid/resp_rdata/resp_err (response),
//           mem_addr/mem_din/mem_we/mem_sel/mem_dout (RAM bus).
// Modports: slave  - the memory access unit itself
//           master - the CPU datapath / RAM side driving it
// ---------------------------------------------------------------------------
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_din, mem_we, mem_sel
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_din, mem_we, mem_sel
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// ---------------------------------------------------------------------------
// mem_access_unit_lane_align
// Purpose : purely combinational byte-lane steering for the load/store unit.
// Ports   : i_offset     - byte offset within the word (addr[1:0])
//           i_size       - access size (SZ_B/SZ_H/SZ_W)
//           i_unsigned   - zero-extend loads instead of sign-extending
//           i_rdWord     - word currently read from the RAM
//           i_oldWord    - word captured earlier for a read-modify-write
//           i_wdata      - right-aligned store data
//           o_sel        - byte-lane mask of the access
//           o_loadData   - extracted and extended load result
//           o_mergeData  - i_oldWord with the selected lanes replaced
// ---------------------------------------------------------------------------
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdWord,
  input  logic [31:0] i_oldWord,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_loadData,
  output logic [31:0] o_mergeData
);

  logic [4:0]  w_shift;
  logic [31:0] w_lanes;
  logic [31:0] w_byteMask;

  // Loads shift the addressed lane down to bit 0 and then extend from the
  // top bit of the byte or halfword. Stores shift the data up into place and
  // overwrite only the masked lanes of the old word, so a word store simply
  // passes the new data through.
  always_comb begin
    w_shift     = {i_offset, 3'b000};
    w_lanes     = i_rdWord >> w_shift;
    o_sel       = laneMask(i_size, i_offset);
    w_byteMask  = {{8{o_sel[3]}}, {8{o_sel[2]}}, {8{o_sel[1]}}, {8{o_sel[0]}}};
    o_mergeData = (i_oldWord & ~w_byteMask) | ((i_wdata << w_shift) & w_byteMask);
    case (i_size)
      SZ_B:    o_loadData = {{24{~i_unsigned & w_lanes[7]}}, w_lanes[7:0]};
      SZ_H:    o_loadData = {{16{~i_unsigned & w_lanes[15]}}, w_lanes[15:0]};
      default: o_loadData = w_lanes;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Purpose : load/store front end between the CPU datapath and a word-wide
//           data RAM with a single write enable. Sub-word stores are done as
//           read-modify-write; illegal requests are answered with an error
//           without any RAM cycle.
// Ports   : CLK - clock, rising edge
//           RST - synchronous active-high reset
//           bus - mem_access_unit_if.slave (request, response and RAM bus)
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 10
)(
  input logic              CLK,
  input logic              RST,
  mem_access_unit_if.slave bus
);

  state_e            r_state;
  state_e            w_nextState;
  logic [ADDR_W+1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_we;
  logic              r_unsigned;
  logic              r_err;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_memWord;

  logic              w_accept;
  logic              w_reqErr;
  logic              w_busActive;
  logic [3:0]        w_sel;
  logic [31:0]       w_loadData;
  logic [31:0]       w_mergeData;

  mem_access_unit_lane_align u_laneAlign (
    .i_offset    (r_addr[1:0]),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_rdWord    (bus.mem_dout),
    .i_oldWord   (r_memWord),
    .i_wdata     (r_wdata),
    .o_sel       (w_sel),
    .o_loadData  (w_loadData),
    .o_mergeData (w_mergeData)
  );

  // Legality of the incoming request is judged on the raw request so that a
  // bad access goes straight to RESP and never drives the RAM bus.
  always_comb begin
    w_accept = bus.req_valid && (r_state == IDLE);
    w_reqErr = (bus.req_size == 2'b11)
            || ((bus.req_size == SZ_H) && bus.req_addr[0])
            || ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00))
            || (|bus.req_addr[31:ADDR_W+2]);
  end

  // State register; reset always returns to IDLE, which also abandons a
  // pending read-modify-write before it reaches WR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: word stores skip the read, sub-word stores read first
  // and then write, loads read and respond.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_reqErr) begin
            w_nextState = RESP;
          end else if (bus.req_we && (bus.req_size == SZ_W)) begin
            w_nextState = WR;
          end else begin
            w_nextState = RD;
          end
        end
      end
      RD:      w_nextState = r_we ? WR : RESP;
      WR:      w_nextState = RESP;
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture on acceptance, plus the RD-cycle snapshot of the RAM
  // word: it feeds the store merge and, for loads, the extracted result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr     <= '0;
      r_size     <= SZ_B;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_memWord  <= '0;
    end else if (w_accept) begin
      r_addr     <= bus.req_addr[ADDR_W+1:0];
      r_size     <= bus.req_size;
      r_we       <= bus.req_we;
      r_unsigned <= bus.req_unsigned;
      r_err      <= w_reqErr;
      r_wdata    <= bus.req_wdata;
      r_rdata    <= '0;
      r_memWord  <= '0;
    end else if (r_state == RD) begin
      r_memWord <= bus.mem_dout;
      if (!r_we) begin
        r_rdata <= w_loadData;
      end
    end
  end

  // Output gating: the RAM bus is only active in RD/WR, write data only in
  // WR, and the response fields are forced to zero outside RESP.
  always_comb begin
    w_busActive    = (r_state == RD) || (r_state == WR);
    bus.req_ready  = (r_state == IDLE);
    bus.mem_we     = (r_state == WR);
    bus.mem_addr   = w_busActive ? r_addr[ADDR_W+1:2] : '0;
    bus.mem_sel    = w_busActive ? w_sel : 4'b0000;
    bus.mem_din    = (r_state == WR) ? w_mergeData : 32'h0;
    bus.resp_valid = (r_state == RESP);
    bus.resp_err   = (r_state == RESP) && r_err;
    bus.resp_rdata = (r_state == RESP) ? r_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Purpose : directed self-checking bench for mem_access_unit with a small
//           word-wide RAM model behind the RAM bus.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int ADDR_W = 10;

  logic clk;
  logic rst;

  int total;
  int bad;

  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic        loadEn;
  logic [ADDR_W-1:0] loadAddr;
  logic [31:0] loadData;

  logic [31:0] rRdata;
  logic        rErr;
  int          lat;
  int          weCnt;
  int          weCycle;
  logic [31:0] weDin;
  logic [3:0]  weSel;
  logic [ADDR_W-1:0] weAddr;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word RAM with asynchronous read; the bench preloads it through the same
  // single write port the unit uses.
  assign bus.mem_dout = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (loadEn) begin
      ram[loadAddr] <= loadData;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_din;
    end
  end

  // Safety net so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    @(negedge clk);
    loadEn   = 1'b1;
    loadAddr = addr;
    loadData = data;
    @(negedge clk);
    loadEn   = 1'b0;
  endtask

  // Issues one request from an idle unit and follows it for a bounded number
  // of cycles, recording response latency, result and any write strobes.
  task automatic applyStimulus(input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata);
    bit done;
    @(negedge clk);
    checkOutput("readyBeforeReq", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    lat     = 0;
    weCnt   = 0;
    weCycle = 0;
    weDin   = '0;
    weSel   = '0;
    weAddr  = '0;
    rRdata  = '0;
    rErr    = 1'b0;
    done    = 1'b0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.mem_we) begin
        weCnt++;
        weCycle = c;
        weDin   = bus.mem_din;
        weSel   = bus.mem_sel;
        weAddr  = bus.mem_addr;
      end
      if (bus.resp_valid) begin
        lat    = c;
        rRdata = bus.resp_rdata;
        rErr   = bus.resp_err;
        done   = 1'b1;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    loadEn   = 1'b0;
    loadAddr = '0;
    loadData = '0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    preload(10'd3, 32'h8077_66F5);
    preload(10'd5, 32'h1122_3344);

    checkOutput("rstReady",     32'(bus.req_ready),  32'd1);
    checkOutput("rstRespValid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rstRespErr",   32'(bus.resp_err),   32'd0);
    checkOutput("rstMemWe",     32'(bus.mem_we),     32'd0);
    checkOutput("rstMemAddr",   32'(bus.mem_addr),   32'd0);
    checkOutput("rstMemDin",    bus.mem_din,         32'd0);
    checkOutput("rstMemSel",    32'(bus.mem_sel),    32'd0);
    checkOutput("rstRdata",     bus.resp_rdata,      32'd0);
    rst = 1'b0;

    // Loads from word 3 = 0x8077_66F5
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0);
    checkOutput("lbData", rRdata, 32'hFFFF_FFF5);
    checkOutput("lbLat",  32'(lat), 32'd2);
    checkOutput("lbWe",   32'(weCnt), 32'd0);

    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_000F, 32'h0);
    checkOutput("lbuData", rRdata, 32'h0000_0080);

    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_000E, 32'h0);
    checkOutput("lhData", rRdata, 32'hFFFF_8077);
    checkOutput("lhErr",  32'(rErr), 32'd0);

    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_000E, 32'h0);
    checkOutput("lhuData", rRdata, 32'h0000_8077);

    // Byte store into lane 1 of word 3
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_00AB);
    checkOutput("sbWeCnt",   32'(weCnt),   32'd1);
    checkOutput("sbWeCycle", 32'(weCycle), 32'd2);
    checkOutput("sbDin",     weDin,        32'h8077_ABF5);
    checkOutput("sbSel",     32'(weSel),   32'h2);
    checkOutput("sbLat",     32'(lat),     32'd3);
    checkOutput("sbRdata",   rRdata,       32'd0);
    checkOutput("sbRam",     ram[3],       32'h8077_ABF5);

    // Word store then read-back
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678);
    checkOutput("swWeCnt",   32'(weCnt),   32'd1);
    checkOutput("swWeCycle", 32'(weCycle), 32'd1);
    checkOutput("swAddr",    32'(weAddr),  32'd4);
    checkOutput("swSel",     32'(weSel),   32'hF);
    checkOutput("swDin",     weDin,        32'h1234_5678);
    checkOutput("swLat",     32'(lat),     32'd2);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    checkOutput("lwData", rRdata, 32'h1234_5678);

    // Error cases: response one cycle after accept, RAM untouched
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
    checkOutput("errLwMisErr", 32'(rErr),  32'd1);
    checkOutput("errLwMisLat", 32'(lat),   32'd1);
    checkOutput("errLwMisWe",  32'(weCnt), 32'd0);
    checkOutput("errLwMisData", rRdata,    32'd0);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_BEEF);
    checkOutput("errShMisErr", 32'(rErr),  32'd1);
    checkOutput("errShMisLat", 32'(lat),   32'd1);
    checkOutput("errShMisWe",  32'(weCnt), 32'd0);

    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0);
    checkOutput("errOorErr", 32'(rErr),  32'd1);
    checkOutput("errOorLat", 32'(lat),   32'd1);
    checkOutput("errOorWe",  32'(weCnt), 32'd0);

    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
    checkOutput("errSizeErr", 32'(rErr),  32'd1);
    checkOutput("errSizeLat", 32'(lat),   32'd1);
    checkOutput("errSizeWe",  32'(weCnt), 32'd0);

    // Reset in the RD cycle of a byte store to word 5
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0000_0014;
    bus.req_wdata    = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("rstRdSel", 32'(bus.mem_sel), 32'h1);
    checkOutput("rstRdWe",  32'(bus.mem_we),  32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstRdIdle", 32'(bus.req_ready), 32'd1);
    weCnt = 0;
    lat   = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.mem_we) weCnt++;
      if (bus.resp_valid) lat++;
      @(negedge clk);
    end
    checkOutput("rstRdNoWe",   32'(weCnt), 32'd0);
    checkOutput("rstRdNoResp", 32'(lat),   32'd0);
    checkOutput("rstRdRam",    ram[5],     32'h1122_3344);

    // Back-to-back: request held valid across RESP
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2bC1Ready", 32'(bus.req_ready),  32'd0);
    @(negedge clk);
    checkOutput("b2bC2Resp",  32'(bus.resp_valid), 32'd1);
    checkOutput("b2bC2Data",  bus.resp_rdata,      32'h1234_5678);
    @(negedge clk);
    checkOutput("b2bC3Ready", 32'(bus.req_ready),  32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("b2bC4Sel",   32'(bus.mem_sel),    32'hF);
    @(negedge clk);
    checkOutput("b2bC5Resp",  32'(bus.resp_valid), 32'd1);
    checkOutput("b2bC5Data",  bus.resp_rdata,      32'h1234_5678);
    @(negedge clk);
    checkOutput("b2bIdle",    32'(bus.req_ready),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
